// File: rtl/instr_fetch_buffer.sv
// Fetch stage: drives instruction memory over req/ack and queues {PC, Instr} in a small FIFO.
// Define IFETCH_PERF_EN to add the perf_fetched / perf_empty_stall / perf_flushes counters.
module instr_fetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        PCSrc,
  input  logic [31:0] branch_target,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [31:0] Instr,
  output logic [31:0] PC
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_empty_stall,
  output logic [15:0] perf_flushes
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic {FETCH, DISCARD} state_t;

  state_t        state;
  logic [31:0]   mem_pc  [DEPTH];
  logic [31:0]   mem_ins [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_nxt, wr_nxt;
  logic [AW:0]   count, cnt_nxt;
  logic [31:0]   tgt_q;
  logic [31:0]   tgt_al;
  logic [31:0]   head_pc, head_ins;
  logic          ack_v, push, pop, req_nxt;

  assign tgt_al = branch_target & 32'hFFFF_FFFC;
  assign ack_v  = imem_ack & imem_req;
  assign pop    = instr_valid & instr_ready & ~PCSrc;
  assign push   = ack_v & ~PCSrc & (state == FETCH);

  always_comb begin
    rd_nxt   = rd_ptr;
    wr_nxt   = wr_ptr;
    cnt_nxt  = count;
    head_pc  = mem_pc[rd_ptr];
    head_ins = mem_ins[rd_ptr];
    if (PCSrc) begin
      rd_nxt  = '0;
      wr_nxt  = '0;
      cnt_nxt = '0;
    end else begin
      if (pop)  rd_nxt = rd_ptr + AW'(1);
      if (push) wr_nxt = wr_ptr + AW'(1);
      cnt_nxt = count + (AW+1)'(push) - (AW+1)'(pop);
      // The registered head must see a word pushed into an otherwise empty FIFO this cycle
      if (push && cnt_nxt == (AW+1)'(1)) begin
        head_pc  = imem_addr;
        head_ins = imem_rdata;
      end else begin
        head_pc  = mem_pc[rd_nxt];
        head_ins = mem_ins[rd_nxt];
      end
    end
    // An issued request stays up until acked; otherwise ask only if the word will fit
    if (imem_req && !ack_v) req_nxt = 1'b1;
    else                    req_nxt = (cnt_nxt < (AW+1)'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]  <= imem_addr;
      mem_ins[wr_ptr] <= imem_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= FETCH;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC & 32'hFFFF_FFFC;
      instr_valid <= 1'b0;
      Instr       <= '0;
      PC          <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      tgt_q       <= '0;
    end else begin
      imem_req    <= req_nxt;
      rd_ptr      <= rd_nxt;
      wr_ptr      <= wr_nxt;
      count       <= cnt_nxt;
      instr_valid <= (cnt_nxt != '0);
      if (cnt_nxt != '0) begin
        PC    <= head_pc;
        Instr <= head_ins;
      end
      case (state)
        FETCH: begin
          if (PCSrc) begin
            if (imem_req && !ack_v) begin
              tgt_q <= tgt_al;
              state <= DISCARD;
            end else begin
              imem_addr <= tgt_al;
            end
          end else if (ack_v) begin
            imem_addr <= imem_addr + 32'd4;
          end
        end
        DISCARD: begin
          if (ack_v) begin
            imem_addr <= PCSrc ? tgt_al : tgt_q;
            state     <= FETCH;
          end else if (PCSrc) begin
            tgt_q <= tgt_al;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched     <= '0;
      perf_empty_stall <= '0;
      perf_flushes     <= '0;
    end else begin
      if (push)         perf_fetched     <= perf_fetched + 32'd1;
      if (!instr_valid) perf_empty_stall <= perf_empty_stall + 32'd1;
      if (PCSrc)        perf_flushes     <= perf_flushes + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Bench for instr_fetch_buffer: directed vector table, corner sequences, and random traffic
// checked against a queue-based reference model.
module tb_instr_fetch_buffer;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        PCSrc;
  logic [31:0] branch_target;
  logic        instr_ready;
  logic        instr_valid;
  logic [31:0] Instr;
  logic [31:0] PC;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched, perf_empty_stall;
  logic [15:0] perf_flushes;
`endif

  instr_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .PCSrc(PCSrc),
    .branch_target(branch_target), .instr_ready(instr_ready),
    .instr_valid(instr_valid), .Instr(Instr), .PC(PC)
`ifdef IFETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_empty_stall(perf_empty_stall),
    .perf_flushes(perf_flushes)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of fetched words plus the request bookkeeping
  typedef struct {logic [31:0] pc; logic [31:0] ins;} ent_t;
  ent_t        q[$];
  bit          m_req, m_disc;
  logic [31:0] m_addr, m_tgt, m_pc, m_ins;
  int          m_pushes, m_flushes, m_empty;

  task automatic model_reset();
    q.delete();
    m_req = 1'b0; m_disc = 1'b0;
    m_addr = 32'h0; m_tgt = 32'h0; m_pc = 32'h0; m_ins = 32'h0;
    m_pushes = 0; m_flushes = 0; m_empty = 0;
  endtask

  task automatic model_edge(input bit ack, input logic [31:0] rd, input bit br,
                            input logic [31:0] tgt, input bit rdy);
    bit ackv;
    bit had;
    ackv = ack && m_req;
    had  = (q.size() > 0);
    if (!had) m_empty++;
    if (br) begin
      m_flushes++;
      q.delete();
      if (m_req && !ackv) begin
        m_disc = 1'b1;
        m_tgt  = tgt & 32'hFFFF_FFFC;
      end else begin
        m_disc = 1'b0;
        m_addr = tgt & 32'hFFFF_FFFC;
      end
    end else begin
      if (rdy && had) void'(q.pop_front());
      if (ackv) begin
        if (m_disc) begin
          m_disc = 1'b0;
          m_addr = m_tgt;
        end else begin
          q.push_back('{pc: m_addr, ins: rd});
          m_pushes++;
          m_addr = m_addr + 32'd4;
        end
      end
    end
    m_req = (m_req && !ackv) ? 1'b1 : (q.size() < DEPTH);
    if (q.size() > 0) begin
      m_pc  = q[0].pc;
      m_ins = q[0].ins;
    end
  endtask

  task automatic step(input bit ack, input logic [31:0] rd, input bit br,
                      input logic [31:0] tgt, input bit rdy);
    imem_ack = ack; imem_rdata = rd; PCSrc = br; branch_target = tgt; instr_ready = rdy;
    @(posedge clk);
    model_edge(ack, rd, br, tgt, rdy);
    #1;
    chk("imem_req",    32'(imem_req),    32'(m_req));
    chk("imem_addr",   imem_addr,        m_addr);
    chk("instr_valid", 32'(instr_valid), 32'(q.size() > 0));
    chk("PC",          PC,               m_pc);
    chk("Instr",       Instr,            m_ins);
  endtask

  task automatic do_reset();
    reset = 1'b0; imem_ack = 1'b0; PCSrc = 1'b0; instr_ready = 1'b0;
    imem_rdata = '0; branch_target = '0;
    model_reset();
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  typedef struct {
    bit ack; logic [31:0] rd; bit br; logic [31:0] tgt; bit rdy;
    bit e_req; logic [31:0] e_addr; bit e_valid; logic [31:0] e_pc; logic [31:0] e_ins;
  } vec_t;

  function automatic vec_t mkv(bit ack, logic [31:0] rd, bit br, logic [31:0] tgt, bit rdy,
                               bit e_req, logic [31:0] e_addr, bit e_valid,
                               logic [31:0] e_pc, logic [31:0] e_ins);
    vec_t v;
    v.ack = ack; v.rd = rd; v.br = br; v.tgt = tgt; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc; v.e_ins = e_ins;
    return v;
  endfunction

  vec_t tbl[11];

  initial begin
    // Reset release, streaming, 3-cycle ack wait with redirect, then redirect on ack+pop
    tbl[0]  = mkv(1'b0, 32'h0,         1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   1'b0, 32'h0,   32'h0);
    tbl[1]  = mkv(1'b1, 32'h1111_0000, 1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   1'b1, 32'h0,   32'h1111_0000);
    tbl[2]  = mkv(1'b1, 32'h1111_0001, 1'b0, 32'h0,   1'b1, 1'b1, 32'h8,   1'b1, 32'h4,   32'h1111_0001);
    tbl[3]  = mkv(1'b1, 32'h1111_0002, 1'b0, 32'h0,   1'b1, 1'b1, 32'hC,   1'b1, 32'h8,   32'h1111_0002);
    tbl[4]  = mkv(1'b0, 32'h0,         1'b0, 32'h0,   1'b1, 1'b1, 32'hC,   1'b0, 32'h8,   32'h1111_0002);
    tbl[5]  = mkv(1'b0, 32'h0,         1'b1, 32'h103, 1'b1, 1'b1, 32'hC,   1'b0, 32'h8,   32'h1111_0002);
    tbl[6]  = mkv(1'b0, 32'h0,         1'b0, 32'h0,   1'b1, 1'b1, 32'hC,   1'b0, 32'h8,   32'h1111_0002);
    tbl[7]  = mkv(1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 1'b0, 32'h8,   32'h1111_0002);
    tbl[8]  = mkv(1'b1, 32'h1111_0003, 1'b0, 32'h0,   1'b1, 1'b1, 32'h104, 1'b1, 32'h100, 32'h1111_0003);
    tbl[9]  = mkv(1'b1, 32'h1111_0004, 1'b0, 32'h0,   1'b0, 1'b1, 32'h108, 1'b1, 32'h100, 32'h1111_0003);
    tbl[10] = mkv(1'b1, 32'h1111_0005, 1'b1, 32'h40,  1'b1, 1'b1, 32'h40,  1'b0, 32'h100, 32'h1111_0003);

    do_reset();
    chk("rst_req",   32'(imem_req),    32'h0);
    chk("rst_addr",  imem_addr,        32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_pc",    PC,               32'h0);
    chk("rst_instr", Instr,            32'h0);

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].ack, tbl[i].rd, tbl[i].br, tbl[i].tgt, tbl[i].rdy);
      chk($sformatf("vec%0d_req", i),   32'(imem_req),    32'(tbl[i].e_req));
      chk($sformatf("vec%0d_addr", i),  imem_addr,        tbl[i].e_addr);
      chk($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(tbl[i].e_valid));
      chk($sformatf("vec%0d_pc", i),    PC,               tbl[i].e_pc);
      chk($sformatf("vec%0d_instr", i), Instr,            tbl[i].e_ins);
    end

    // Fill with ready low: four words, then the request stops
    do_reset();
    for (int i = 0; i < 7; i++) step(imem_req, 32'hA000_0000 + 32'(i), 1'b0, 32'h0, 1'b0);
    chk("full_req",   32'(imem_req),    32'h0);
    chk("full_valid", 32'(instr_valid), 32'h1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d_pc", i), PC, 32'(i) * 32'd4);
      step(imem_req, 32'hB000_0000 + 32'(i), 1'b0, 32'h0, 1'b1);
      if (i == 0) chk("resume_req", 32'(imem_req), 32'h1);
    end

    // Address wrap at the top of the address space
    step(imem_req, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    chk("wrap_tgt", imem_addr, 32'hFFFF_FFFC);
    step(imem_req, 32'hC0DE_0001, 1'b0, 32'h0, 1'b1);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_pc",   PC,        32'hFFFF_FFFC);

    // Asynchronous reset while a request is outstanding, then a late ack
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("pre_rst_req", 32'(imem_req), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("arst_req",   32'(imem_req),    32'h0);
    chk("arst_addr",  imem_addr,        32'h0);
    chk("arst_valid", 32'(instr_valid), 32'h0);
    chk("arst_pc",    PC,               32'h0);
    chk("arst_instr", Instr,            32'h0);
    model_reset();
    imem_ack = 1'b1;
    @(posedge clk);
    #1 reset = 1'b1;
    step(1'b1, 32'hBAD0_BAD0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(imem_req && ($urandom_range(3) != 0), $urandom(), ($urandom_range(15) == 0),
           ($urandom_range(7) == 0) ? 32'hFFFF_FFF8 : $urandom(), ($urandom_range(2) != 0));
    end
`ifdef IFETCH_PERF_EN
    chk("perf_fetched",     perf_fetched,         32'(m_pushes));
    chk("perf_flushes",     32'(perf_flushes),    32'(m_flushes));
    chk("perf_empty_stall", perf_empty_stall,     32'(m_empty));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
